// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receive deserializer: finds byte alignment on COM,
// then emits aligned payload bytes with COM/IDL fillers stripped.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM         = 8'hBC,
    parameter logic [7:0]  IDL         = 8'h7C,
    parameter int unsigned ALIGN_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
    logic [BYTE_W-1:0]  data_d;
    logic               valid_d;
    logic               active_d;
    logic               strobe_d;
    logic               boundary;
    logic               sr_is_com;
    logic [CNT_W-1:0]   com_cnt_inc;

    assign boundary    = (bit_cnt_q == CNT_W'(7));
    assign sr_is_com   = (sr_q == COM);
    assign com_cnt_inc = com_cnt_q + CNT_W'(1);

    // State and output registers
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
            byte_strobe <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            data_out    <= data_d;
            valid_out   <= valid_d;
            active      <= active_d;
            byte_strobe <= strobe_d;
        end
    end

    // Alignment search, COM lock counting and byte emission
    always_comb begin
        state_d   = state_q;
        sr_d      = {sr_q[BYTE_W-2:0], data_in};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        com_cnt_d = com_cnt_q;
        data_d    = data_out;
        valid_d   = valid_out;
        active_d  = active;
        strobe_d  = 1'b0;

        case (state_q)
            SEARCH: begin
                if (sr_is_com) begin
                    com_cnt_d = CNT_W'(1);
                    bit_cnt_d = '0;
                    if (ALIGN_COUNT == 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = LOCKING;
                    end
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (sr_is_com) begin
                        com_cnt_d = com_cnt_inc;
                        if (com_cnt_inc >= CNT_W'(ALIGN_COUNT)) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Misaligned byte: next cycle is a fresh candidate
                        state_d   = SEARCH;
                        com_cnt_d = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (sr_is_com || (sr_q == IDL)) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = sr_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Randomized and directed bench for serial_paralelo_rx, checked every cycle
// against a bit-history reference model plus literal timing expectations.
module tb_serial_paralelo_rx;

    localparam int unsigned ALIGN = 4;
    localparam logic [7:0]  COM   = 8'hBC;
    localparam logic [7:0]  IDL   = 8'h7C;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_strobe;

    serial_paralelo_rx #(.COM(COM), .IDL(IDL), .ALIGN_COUNT(ALIGN)) dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active     (active),
        .byte_strobe(byte_strobe)
    );

    always #5 clk_32f = ~clk_32f;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: full bit history since reset and the anchor cycle
    // of the first COM of the current alignment attempt.
    logic       hist[$];
    int         anchor;
    int         com_seen;
    bit         m_active;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_strobe;
    int         cur_edge;
    bit         chk_en = 1'b0;

    // Per-test observations of the DUT, pinned by literal checks
    int         act_edge;
    int         strobe_cnt;
    int         inv_cnt;
    logic [7:0] inv_last_data;
    int         strobe_edge[256];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [7:0] last8();
        logic [7:0] r = '0;
        int sz = hist.size();
        for (int i = 0; i < 8; i++) begin
            int idx = sz - 8 + i;
            if (idx >= 0) r[7-i] = hist[idx];
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        anchor        = -1;
        com_seen      = 0;
        m_active      = 1'b0;
        exp_data      = '0;
        exp_valid     = 1'b0;
        exp_strobe    = 1'b0;
        cur_edge      = -1;
        act_edge      = -1;
        strobe_cnt    = 0;
        inv_cnt       = 0;
        inv_last_data = '0;
        for (int i = 0; i < 256; i++) strobe_edge[i] = -1;
    endtask

    // Advance the model across the edge that ends cycle n, where the
    // register window holds bits n-8..n-1 and bit b is being sampled.
    task automatic model_edge(input logic b);
        int n = hist.size();
        logic [7:0] w = last8();
        exp_strobe = 1'b0;
        if (anchor < 0) begin
            if (w == COM) begin
                anchor   = n;
                com_seen = 1;
                if (com_seen >= int'(ALIGN)) m_active = 1'b1;
            end
        end else if (((n - anchor) % 8) == 0) begin
            if (m_active) begin
                exp_strobe = 1'b1;
                if (w == COM || w == IDL) begin
                    exp_valid = 1'b0;
                end else begin
                    exp_data  = w;
                    exp_valid = 1'b1;
                end
            end else if (w == COM) begin
                com_seen++;
                if (com_seen >= int'(ALIGN)) m_active = 1'b1;
            end else begin
                anchor   = -1;
                com_seen = 0;
            end
        end
        hist.push_back(b);
        cur_edge = n;
    endtask

    // Single compare process: outputs sampled mid-cycle
    always @(negedge clk_32f) begin
        if (chk_en) begin
            chk("data_out",    int'(data_out),    int'(exp_data));
            chk("valid_out",   int'(valid_out),   int'(exp_valid));
            chk("active",      int'(active),      int'(m_active));
            chk("byte_strobe", int'(byte_strobe), int'(exp_strobe));
            if (active && act_edge < 0) act_edge = cur_edge;
            if (byte_strobe) begin
                strobe_cnt++;
                if (valid_out) strobe_edge[data_out] = cur_edge;
                else begin
                    inv_cnt++;
                    inv_last_data = data_out;
                end
            end
        end
    end

    task automatic step(input logic b);
        #1 data_in = b;
        @(posedge clk_32f);
        model_edge(b);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic send_coms(input int k);
        for (int i = 0; i < k; i++) send_byte(COM);
    endtask

    task automatic do_reset();
        chk_en  = 1'b0;
        reset_L = 1'b0;
        repeat (2) @(posedge clk_32f);
        @(negedge clk_32f);
        model_reset();
        reset_L = 1'b1;
        chk_en  = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle line: nothing must happen
        for (int i = 0; i < 64; i++) step(1'b0);
        @(negedge clk_32f);
        chk("idle_active", int'(active), 0);
        chk("idle_strobes", strobe_cnt, 0);
        chk("idle_data", int'(data_out), 0);

        // Basic lock and payload timing
        do_reset();
        send_coms(4);
        send_byte(8'h7C); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h00);
        @(negedge clk_32f);
        chk("t2_active_edge", act_edge, 32);
        chk("t2_a5_edge", strobe_edge[8'hA5], 48);
        chk("t2_3c_edge", strobe_edge[8'h3C], 56);
        chk("t2_strobes", strobe_cnt, 3);
        chk("t2_idl_strobes", inv_cnt, 1);
        chk("t2_idl_data", int'(inv_last_data), 0);

        // Alignment at bit offset 3
        do_reset();
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)));
        send_coms(4);
        send_byte(8'h55); send_byte(IDL);
        @(negedge clk_32f);
        chk("t3_active_edge", act_edge, 35);
        chk("t3_55_edge", strobe_edge[8'h55], 43);
        chk("t3_strobes", strobe_cnt, 1);

        // Broken lock attempt, then relock
        do_reset();
        send_coms(2); send_byte(8'h12);
        step(1'b0);
        @(negedge clk_32f);
        chk("t4_abort_active", int'(active), 0);
        do_reset();
        send_coms(2); send_byte(8'h12); send_coms(4);
        send_byte(8'h99); send_byte(IDL);
        @(negedge clk_32f);
        chk("t4_active_edge", act_edge, 56);
        chk("t4_99_edge", strobe_edge[8'h99], 64);
        chk("t4_strobes", strobe_cnt, 1);

        // Fillers in ACTIVE hold the previous payload
        do_reset();
        send_coms(4);
        send_byte(8'hF0); send_byte(COM); send_byte(IDL); send_byte(8'h0F);
        send_byte(IDL);
        @(negedge clk_32f);
        chk("t5_f0_edge", strobe_edge[8'hF0], 40);
        chk("t5_filler_strobes", inv_cnt, 2);
        chk("t5_filler_data", int'(inv_last_data), 8'hF0);
        chk("t5_0f_edge", strobe_edge[8'h0F], 64);

        // Asynchronous reset mid-byte in ACTIVE
        do_reset();
        send_coms(4); send_byte(8'hA5); send_byte(IDL);
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        chk_en = 1'b0;
        #3 reset_L = 1'b0;
        #1;
        chk("t6_async_data", int'(data_out), 0);
        chk("t6_async_valid", int'(valid_out), 0);
        chk("t6_async_active", int'(active), 0);
        chk("t6_async_strobe", int'(byte_strobe), 0);
        do_reset();
        send_coms(4); send_byte(8'h81); send_byte(IDL);
        @(negedge clk_32f);
        chk("t6_active_edge", act_edge, 32);
        chk("t6_81_edge", strobe_edge[8'h81], 40);

        // Randomized streams: random offset, possibly broken preambles
        for (int it = 0; it < 12; it++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(0, 12)); i++)
                step(1'($urandom_range(0, 1)));
            for (int i = 0; i < 6; i++) begin
                logic [7:0] v = ($urandom_range(0, 5) == 0) ? 8'($urandom) : COM;
                send_byte(v);
            end
            if ($urandom_range(0, 3) == 0) step(1'($urandom_range(0, 1)));
            for (int i = 0; i < 24; i++) begin
                logic [7:0] v;
                case ($urandom_range(0, 5))
                    0:       v = COM;
                    1:       v = IDL;
                    default: v = 8'($urandom);
                endcase
                send_byte(v);
            end
        end

        @(negedge clk_32f);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
